fpu_seq: RTL

FPU_SEQ -- requirements
Module: fpu_seq

---
 rtl/fpu_seq.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_seq.sv
// fpu_seq: sequential floating-point add/sub/mul unit.
// One operation is in flight at a time. Alignment, multiplication and
// normalisation are iterative, one bit per cycle. Rounding truncates, and
// denormal inputs are flushed to zero.
module fpu_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;              // mantissa including the hidden bit
  localparam int PW = 2 * MW;                 // working width; hidden bit at PW-2
  localparam int EW = EXP_W + 2;              // signed working exponent
  localparam int CW = $clog2(MAN_W + 3);      // holds max(MAN_W+2, MAN_W+1)

  localparam logic [EXP_W-1:0]    EXP_ONES = '1;
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // Flag bit positions: {invalid, overflow, underflow, zero}
  localparam logic [3:0] F_NONE  = 4'b0000;
  localparam logic [3:0] F_INV   = 4'b1000;
  localparam logic [3:0] F_OVF   = 4'b0100;
  localparam logic [3:0] F_UNF   = 4'b0011;
  localparam logic [3:0] F_ZERO  = 4'b0001;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_RSV} op_t;

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, MUL, NORM, PACK, DONE
  } state_t;

  state_t state, state_nx;

  // Captured operation and working registers
  op_t                    op_q;
  logic [W-1:0]           a_q, b_q;
  logic                   sa_q, sb_q;      // operand signs (b already negated for sub)
  logic                   sign_q;          // result sign
  logic signed [EW-1:0]   e_r;             // working exponent
  logic [MW-1:0]          ma, mb;          // mantissas with hidden bit
  logic [PW-1:0]          acc;             // normalisation / product register
  logic [CW-1:0]          cnt;             // ALIGN and MUL iteration counter
  logic                   shift_b;         // 1: b has the smaller exponent
  logic                   byp;             // result already decided (special case)
  logic [W-1:0]           byp_res;
  logic [3:0]             byp_flg;
  logic [W-1:0]           res_q;
  logic [3:0]             flg_q;

  // Field decode of the captured operands
  logic                   sa_f, sb_f;
  logic [EXP_W-1:0]       ea_f, eb_f;
  logic [MAN_W-1:0]       fa_f, fb_f;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sa_f   = a_q[W-1];
  assign sb_f   = b_q[W-1] ^ (op_q == OP_SUB);
  assign ea_f   = a_q[W-2 -: EXP_W];
  assign eb_f   = b_q[W-2 -: EXP_W];
  assign fa_f   = a_q[MAN_W-1:0];
  assign fb_f   = b_q[MAN_W-1:0];
  assign a_zero = (ea_f == '0);
  assign b_zero = (eb_f == '0);
  assign a_inf  = (ea_f == EXP_ONES) && (fa_f == '0);
  assign b_inf  = (eb_f == EXP_ONES) && (fb_f == '0);
  assign a_nan  = (ea_f == EXP_ONES) && (fa_f != '0);
  assign b_nan  = (eb_f == EXP_ONES) && (fb_f != '0);

  // Alignment distance, saturated so a fully shifted-out mantissa stops early
  logic                   a_ge;
  logic [EXP_W-1:0]       dexp;
  logic [CW-1:0]          shift_n;

  assign a_ge    = (ea_f >= eb_f);
  assign dexp    = a_ge ? (ea_f - eb_f) : (eb_f - ea_f);
  assign shift_n = (int'(dexp) > MAN_W + 2) ? CW'(MAN_W + 2) : CW'(dexp);

  // Special-operand classification: NaN, infinity and zero shortcuts
  logic                   spec;
  logic [W-1:0]           spec_res;
  logic [3:0]             spec_flg;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the decision tree can leave one unassigned and infer a latch.
    spec     = 1'b1;
    spec_res = QNAN;
    spec_flg = F_INV;
    if (op_q == OP_RSV || a_nan || b_nan) begin
      spec_res = QNAN;
      spec_flg = F_INV;
    end else if (op_q == OP_MUL) begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) begin
        spec_res = QNAN;
        spec_flg = F_INV;
      end else if (a_inf || b_inf) begin
        spec_res = {sa_f ^ sb_f, EXP_ONES, {MAN_W{1'b0}}};
        spec_flg = F_NONE;
      end else if (a_zero || b_zero) begin
        spec_res = {sa_f ^ sb_f, {(W-1){1'b0}}};
        spec_flg = F_ZERO;
      end else begin
        spec = 1'b0;
      end
    end else begin
      if (a_inf && b_inf && (sa_f != sb_f)) begin
        spec_res = QNAN;
        spec_flg = F_INV;
      end else if (a_inf) begin
        spec_res = {sa_f, EXP_ONES, {MAN_W{1'b0}}};
        spec_flg = F_NONE;
      end else if (b_inf) begin
        spec_res = {sb_f, EXP_ONES, {MAN_W{1'b0}}};
        spec_flg = F_NONE;
      end else if (a_zero && b_zero) begin
        // Only -0 + -0 keeps the negative sign
        spec_res = {sa_f & sb_f, {(W-1){1'b0}}};
        spec_flg = F_ZERO;
      end else if (a_zero) begin
        spec_res = {sb_f, b_q[W-2:0]};
        spec_flg = F_NONE;
      end else if (b_zero) begin
        spec_res = a_q;
        spec_flg = F_NONE;
      end else begin
        spec = 1'b0;
      end
    end
  end

  // Magnitude add/subtract of the aligned mantissas
  logic [MW:0]            add_sum;
  logic                   add_sign;
  logic                   add_zero;

  always_comb begin
    add_sum  = '0;
    add_sign = sa_q;
    add_zero = 1'b0;
    if (sa_q == sb_q) begin
      add_sum = {1'b0, ma} + {1'b0, mb};
    end else if (ma > mb) begin
      add_sum = {1'b0, ma - mb};
    end else if (mb > ma) begin
      add_sum  = {1'b0, mb - ma};
      add_sign = sb_q;
    end else begin
      add_zero = 1'b1;
    end
  end

  // One shift-add step: add the multiplicand into the upper half, then shift right
  logic [MW:0]            mul_sum;
  assign mul_sum = {1'b0, acc[PW-1:MW]} + (mb[0] ? {1'b0, ma} : {(MW+1){1'b0}});

  // Final packing of a normalised value, with overflow/underflow saturation
  logic [W-1:0]           pack_res;
  logic [3:0]             pack_flg;

  always_comb begin
    pack_res = '0;
    pack_flg = F_NONE;
    if (byp) begin
      pack_res = byp_res;
      pack_flg = byp_flg;
    end else if (e_r >= EXP_MAX) begin
      pack_res = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      pack_flg = F_OVF;
    end else if (e_r[EW-1] || (e_r == '0)) begin
      pack_res = {sign_q, {(W-1){1'b0}}};
      pack_flg = F_UNF;
    end else begin
      pack_res = {sign_q, e_r[EXP_W-1:0], acc[PW-3 -: MAN_W]};
      pack_flg = F_NONE;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the blocks are evaluated in.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = UNPACK;
      end
      UNPACK: begin
        if (spec)                 state_nx = PACK;
        else if (op_q == OP_MUL)  state_nx = MUL;
        else if (shift_n != '0)   state_nx = ALIGN;
        else                      state_nx = ADD;
      end
      ALIGN:  if (cnt == CW'(1)) state_nx = ADD;
      ADD:    state_nx = add_zero ? PACK : NORM;
      MUL:    if (cnt == CW'(1)) state_nx = NORM;
      NORM:   if (!acc[PW-1] && acc[PW-2]) state_nx = PACK;
      PACK:   state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, alignment, add, multiply, normalise, pack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sign_q  <= 1'b0;
      e_r     <= '0;
      ma      <= '0;
      mb      <= '0;
      acc     <= '0;
      cnt     <= '0;
      shift_b <= 1'b0;
      byp     <= 1'b0;
      byp_res <= '0;
      byp_flg <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= op_t'(op);
            a_q  <= a;
            b_q  <= b;
          end
        end
        UNPACK: begin
          byp     <= spec;
          byp_res <= spec_res;
          byp_flg <= spec_flg;
          sa_q    <= sa_f;
          sb_q    <= sb_f;
          ma      <= {1'b1, fa_f};
          mb      <= {1'b1, fb_f};
          acc     <= '0;
          if (op_q == OP_MUL) begin
            sign_q <= sa_f ^ sb_f;
            e_r    <= $signed({2'b00, ea_f}) + $signed({2'b00, eb_f}) - BIAS;
            cnt    <= CW'(MAN_W + 1);
          end else begin
            e_r     <= $signed({2'b00, (a_ge ? ea_f : eb_f)});
            cnt     <= shift_n;
            shift_b <= a_ge;
          end
        end
        ALIGN: begin
          if (shift_b) mb <= mb >> 1;
          else         ma <= ma >> 1;
          cnt <= cnt - CW'(1);
        end
        ADD: begin
          if (add_zero) begin
            byp     <= 1'b1;
            byp_res <= '0;
            byp_flg <= F_ZERO;
          end else begin
            sign_q <= add_sign;
            acc    <= {add_sum, {MAN_W{1'b0}}};
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[MW-1:1]};
          mb  <= mb >> 1;
          cnt <= cnt - CW'(1);
        end
        NORM: begin
          if (acc[PW-1]) begin
            acc <= acc >> 1;
            e_r <= e_r + EW'(1);
          end else if (!acc[PW-2]) begin
            acc <= acc << 1;
            e_r <= e_r - EW'(1);
          end
        end
        PACK: begin
          res_q <= pack_res;
          flg_q <= pack_flg;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign result = res_q;
  assign flags  = flg_q;

endmodule
